// File: rtl/train_scheduler_if.sv
// train_scheduler_if
//   Bundles the control/status signals of the training-run scheduler.
//   The master side (test driver or host controller) drives the training
//   request, frame-capture strobe and classifier results. The slave side
//   (train_scheduler) drives the datapath strobes and the run status.
//
//   Signals
//     Train    m->s  level, requests a training run
//     XFull    m->s  pulse, frame pixel vector fully captured
//     Hw       m->s  classifier decision, valid CLS_LAT cycles after Classify
//     Label    m->s  target class for the current frame
//     NewFrame s->m  pulse, clear accumulator for the next frame
//     ComputeH s->m  pulse, latch the weighted sum
//     Classify s->m  pulse, start classification
//     UpRule   s->m  pulse, apply the weight delta
//     Busy     s->m  level, run in progress
//     Done     s->m  level, run complete
//     Epoch    s->m  [3:0] current epoch index
//     ErrCnt   s->m  [7:0] misclassifications in the last completed epoch
interface train_scheduler_if;
  logic       Train;
  logic       XFull;
  logic       Hw;
  logic       Label;
  logic       NewFrame;
  logic       ComputeH;
  logic       Classify;
  logic       UpRule;
  logic       Busy;
  logic       Done;
  logic [3:0] Epoch;
  logic [7:0] ErrCnt;

  modport master (
    output Train, XFull, Hw, Label,
    input  NewFrame, ComputeH, Classify, UpRule, Busy, Done, Epoch, ErrCnt
  );

  modport slave (
    input  Train, XFull, Hw, Label,
    output NewFrame, ComputeH, Classify, UpRule, Busy, Done, Epoch, ErrCnt
  );
endinterface

// File: rtl/train_scheduler.sv
// train_scheduler
//   Sequences a perceptron-style training run: for every frame it waits for
//   the pixel vector, strobes the weighted-sum latch, launches the classifier,
//   compares its decision with the label and, on a miss, strobes the weight
//   update. Frames are grouped into epochs; the run ends after MAX_EPOCHS
//   epochs (or earlier, see below) and holds Done until Train drops.
//
//   Parameters
//     FRAMES_PER_EPOCH  frames per epoch (2..256)
//     MAX_EPOCHS        epoch limit (1..16)
//     CLS_LAT           cycles from Classify until Hw is valid (1..15)
//
//   Ports
//     Clk   rising-edge system clock
//     RST   synchronous, active-high reset
//     bus   train_scheduler_if.slave (see interface file for signal list)
//
//   Build option
//     TRAIN_EARLY_STOP_EN  when defined, a run also ends after any epoch that
//                          completes with zero misclassifications.
//
//   All strobes and Busy/Done are decoded from the registered state only.
module train_scheduler #(
  parameter int unsigned FRAMES_PER_EPOCH = 16,
  parameter int unsigned MAX_EPOCHS       = 8,
  parameter int unsigned CLS_LAT          = 2
) (
  input  logic                Clk,
  input  logic                RST,
  train_scheduler_if.slave    bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WAIT_X,
    S_COMPUTE,
    S_CLASSIFY,
    S_WAIT_CLS,
    S_DECIDE,
    S_UPDATE,
    S_FRAME_END,
    S_DONE
  } state_e;

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_EPOCH - 1);
  localparam logic [3:0] LAST_EPOCH = 4'(MAX_EPOCHS - 1);
  localparam logic [3:0] LAT        = 4'(CLS_LAT);

  state_e     state_q,   state_d;
  logic [7:0] frame_q,   frame_d;    // frame index within the epoch
  logic [7:0] err_q,     err_d;      // running misclassifications this epoch
  logic [7:0] err_cnt_q, err_cnt_d;  // published count of the last full epoch
  logic [3:0] epoch_q,   epoch_d;
  logic [3:0] lat_q,     lat_d;      // classifier latency countdown

  logic last_frame;
  logic early_stop;
  logic terminate;
  logic mismatch;

  assign last_frame = (frame_q == LAST_FRAME);
  assign mismatch   = (bus.Hw != bus.Label);

`ifdef TRAIN_EARLY_STOP_EN
  assign early_stop = (err_q == '0);
`else
  assign early_stop = 1'b0;
`endif

  assign terminate = (epoch_q == LAST_EPOCH) || early_stop;

  // Next-state and counter updates
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    lat_d     = lat_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Train) begin
          // A new run restarts all run counters; the published error count
          // of the previous run stays visible until an epoch completes.
          epoch_d = '0;
          frame_d = '0;
          err_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        state_d = S_WAIT_X;
      end

      S_WAIT_X: begin
        if (!bus.Train) begin
          state_d = S_IDLE;
        end else if (bus.XFull) begin
          state_d = S_COMPUTE;
        end
      end

      S_COMPUTE: begin
        state_d = S_CLASSIFY;
      end

      S_CLASSIFY: begin
        lat_d = LAT;
        // With a single-cycle classifier Hw is already valid next cycle.
        if (LAT <= 4'd1) begin
          state_d = S_DECIDE;
        end else begin
          state_d = S_WAIT_CLS;
        end
      end

      S_WAIT_CLS: begin
        // The count includes the CLASSIFY cycle, so DECIDE is entered when
        // the countdown would reach 1, i.e. exactly CLS_LAT cycles after
        // Classify was high.
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd2) begin
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 8'd1;
          end
          state_d = S_UPDATE;
        end else begin
          state_d = S_FRAME_END;
        end
      end

      S_UPDATE: begin
        state_d = S_FRAME_END;
      end

      S_FRAME_END: begin
        if (!bus.Train) begin
          state_d = S_IDLE;
        end else if (!last_frame) begin
          frame_d = frame_q + 8'd1;
          state_d = S_START;
        end else begin
          err_cnt_d = err_q;
          frame_d   = '0;
          if (terminate) begin
            state_d = S_DONE;
          end else begin
            err_d   = '0;
            epoch_d = epoch_q + 4'd1;
            state_d = S_START;
          end
        end
      end

      S_DONE: begin
        if (!bus.Train) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.NewFrame = 1'b0;
    bus.ComputeH = 1'b0;
    bus.Classify = 1'b0;
    bus.UpRule   = 1'b0;
    bus.Busy     = 1'b1;
    bus.Done     = 1'b0;

    unique case (state_q)
      S_IDLE:     bus.Busy     = 1'b0;
      S_START:    bus.NewFrame = 1'b1;
      S_COMPUTE:  bus.ComputeH = 1'b1;
      S_CLASSIFY: bus.Classify = 1'b1;
      S_UPDATE:   bus.UpRule   = 1'b1;
      S_DONE: begin
        bus.Busy = 1'b0;
        bus.Done = 1'b1;
      end
      default: ;
    endcase

    bus.Epoch  = epoch_q;
    bus.ErrCnt = err_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      lat_q     <= lat_d;
    end
  end

endmodule
